ifetch_unit: RTL

// Instruction fetch stage placed directly downstream of the branch/PC control block.

---
 rtl/ifetch_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage. Takes a PC from branch control, fetches
// one instruction word over a req/ack memory port and holds it in the IR until
// decode accepts it. A single pending-PC slot absorbs redirects that arrive while
// a fetch is in flight or while the IR is waiting for decode.
// Optional feature macro: IFETCH_TIMEOUT_EN (fetch timeout with sticky fetch_err).
module ifetch_unit #(
  parameter int AW          = 8,
  parameter int IW          = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  input  logic          pc_load,
  input  logic          flush,
  input  logic          ir_ready,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic          imem_ack,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  output logic          fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t        r_state, w_state_n;
  logic [AW-1:0] r_addr, w_addr_n;
  logic [AW-1:0] r_pend, w_pend_n;
  logic          r_pend_v, w_pend_v_n;
  logic          r_stale, w_stale_n;   // in-flight fetch must be discarded on ack
  logic          r_gap, w_gap_n;       // one-cycle req bubble on a stale-ack reissue
  logic [IW-1:0] r_ir, w_ir_n;
  logic          r_irv, w_irv_n;

  logic          w_req;
  logic          w_ack;
  logic          w_timeout;
  logic          w_slot_v;
  logic [AW-1:0] w_slot;

  // Timeout threshold must fit the 8-bit wait counter.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("ifetch_unit: TIMEOUT_CYC out of range 1..255");
  end

  assign w_req = (r_state == S_WAIT) && !r_gap;
  // An ack only counts while a request is actually on the bus.
  assign w_ack = w_req && imem_ack;

  // Pending slot after this cycle's flush/pc_load: flush empties it first,
  // then a same-cycle pc_load refills it (last PC wins).
  assign w_slot_v = (r_pend_v && !flush) || pc_load;
  assign w_slot   = pc_load ? pc : r_pend;

`ifdef IFETCH_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic       r_err;

  assign w_timeout = w_req && !imem_ack && (r_to_cnt == 8'(TIMEOUT_CYC - 1));

  // Count consecutive request cycles without ack; sticky error on expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_timeout) r_err <= 1'b1;
      if (!w_req || imem_ack) r_to_cnt <= '0;
      else                    r_to_cnt <= r_to_cnt + 8'd1;
    end
  end

  assign fetch_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // Next-state and datapath next values.
  always_comb begin
    w_state_n  = r_state;
    w_addr_n   = r_addr;
    w_pend_n   = r_pend;
    w_pend_v_n = r_pend_v;
    w_stale_n  = r_stale;
    w_gap_n    = 1'b0;
    w_ir_n     = r_ir;
    w_irv_n    = r_irv;
    unique case (r_state)
      S_IDLE: begin
        // Pending slot is consumed immediately; a live pc_load is newer.
        w_pend_v_n = 1'b0;
        if (w_slot_v) begin
          w_addr_n  = w_slot;
          w_state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        w_pend_n   = w_slot;
        w_pend_v_n = w_slot_v;
        if (w_timeout) begin
          w_pend_v_n = 1'b0;
          w_stale_n  = 1'b0;
          w_state_n  = S_IDLE;
        end else if (w_ack) begin
          if (r_stale || flush) begin
            w_stale_n  = 1'b0;
            w_pend_v_n = 1'b0;
            if (w_slot_v) begin
              w_addr_n = w_slot;
              w_gap_n  = 1'b1;
            end else begin
              w_state_n = S_IDLE;
            end
          end else begin
            w_ir_n    = imem_rdata;
            w_irv_n   = 1'b1;
            w_state_n = S_HOLD;
          end
        end else begin
          w_stale_n = r_stale || flush || pc_load;
        end
      end
      S_HOLD: begin
        if (flush) begin
          w_irv_n    = 1'b0;
          w_pend_n   = w_slot;
          w_pend_v_n = pc_load;
          w_state_n  = S_IDLE;
        end else if (ir_ready) begin
          w_irv_n = 1'b0;
          if (r_pend_v) begin
            // Pending PC goes first; a same-cycle pc_load supersedes it,
            // so that fetch is marked stale and the new PC is queued.
            w_addr_n   = r_pend;
            w_pend_n   = pc;
            w_pend_v_n = pc_load;
            w_stale_n  = pc_load;
            w_state_n  = S_WAIT;
          end else if (pc_load) begin
            w_addr_n  = pc;
            w_state_n = S_WAIT;
          end else begin
            w_state_n = S_IDLE;
          end
        end else if (pc_load) begin
          w_pend_n   = pc;
          w_pend_v_n = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_stale  <= 1'b0;
      r_gap    <= 1'b0;
      r_ir     <= '0;
      r_irv    <= 1'b0;
    end else begin
      r_addr   <= w_addr_n;
      r_pend   <= w_pend_n;
      r_pend_v <= w_pend_v_n;
      r_stale  <= w_stale_n;
      r_gap    <= w_gap_n;
      r_ir     <= w_ir_n;
      r_irv    <= w_irv_n;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_addr;
  assign ir        = r_ir;
  assign ir_valid  = r_irv;

endmodule
